// File: rtl/dti_pack.sv
// Shared DTI constants and types.
// AXIS_* widths size the stream payload, TBU_NUM* size the TBU fan-in and
// the source-id field, TRANSACTION_MAX_NUM bounds a legal message length.
package dti_pack;

    localparam int unsigned AXIS_DATA_WIDTH     = 80;
    localparam int unsigned AXIS_KEEP_WIDTH     = AXIS_DATA_WIDTH / 8;
    localparam int unsigned TBU_NUM             = 2;
    localparam int unsigned TBU_NUM_WIDTH       = 6;
    localparam int unsigned TRANSACTION_MAX_NUM = 5;

    // Upstream arbiter: IDLE = free to pick, LOCK = grant held until tlast
    typedef enum logic [0:0] {ARB_IDLE, ARB_LOCK} arb_state_t;

endpackage

// File: rtl/dti_tbu_arb_if.sv
// Bundle of the per-TBU DTI AXI-Stream inputs and the shared upstream link.
// Ports:
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast : one lane per TBU
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast/m_tid : upstream toward TCU
// Modports:
//   master : the arbiter (drives s_tready and the upstream link)
//   slave  : the surroundings (TBU senders and upstream sink)
interface dti_tbu_arb_if #(
    parameter int unsigned TBU_NUM       = dti_pack::TBU_NUM,
    parameter int unsigned TBU_NUM_WIDTH = dti_pack::TBU_NUM_WIDTH,
    parameter int unsigned DATA_WIDTH    = dti_pack::AXIS_DATA_WIDTH,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8
);

    logic [TBU_NUM-1:0]                 s_tvalid;
    logic [TBU_NUM-1:0]                 s_tready;
    logic [TBU_NUM-1:0][DATA_WIDTH-1:0] s_tdata;
    logic [TBU_NUM-1:0][KEEP_WIDTH-1:0] s_tkeep;
    logic [TBU_NUM-1:0]                 s_tlast;

    logic                     m_tvalid;
    logic                     m_tready;
    logic [DATA_WIDTH-1:0]    m_tdata;
    logic [KEEP_WIDTH-1:0]    m_tkeep;
    logic                     m_tlast;
    logic [TBU_NUM_WIDTH-1:0] m_tid;

    modport master (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid
    );

    modport slave (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid
    );

endinterface

// File: rtl/dti_rr_pick.sv
// Combinational round-robin first-one search.
// Ports:
//   req : request vector, one bit per TBU
//   ptr : highest-priority index this round
//   idx : first requesting index at or after ptr (wrapping)
//   any : at least one request present
module dti_rr_pick #(
    parameter int unsigned TBU_NUM = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [TBU_NUM-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    // Walk ptr, ptr+1, ... mod TBU_NUM and keep the first hit
    always_comb begin
        int unsigned j;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned i = 0; i < TBU_NUM; i++) begin
            j = (32'(ptr) + i) % TBU_NUM;
            if (!any && req[PTR_W'(j)]) begin
                idx = PTR_W'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dti_tbu_arb.sv
// Packet-level round-robin arbiter sharing one upstream DTI AXI-Stream link
// between TBU_NUM TBU ports. A grant is held from the first beat of a
// message until its tlast beat; every forwarded beat carries the source
// index on m_tid. One output register stage; err_len flags (sticky) any
// message running past MAX_BEATS beats without altering the traffic.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : per-TBU s_* inputs with s_tready, upstream m_* (registered)
//   err_len    : sticky over-length message flag
module dti_tbu_arb #(
    parameter int unsigned TBU_NUM       = dti_pack::TBU_NUM,
    parameter int unsigned TBU_NUM_WIDTH = dti_pack::TBU_NUM_WIDTH,
    parameter int unsigned DATA_WIDTH    = dti_pack::AXIS_DATA_WIDTH,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned MAX_BEATS     = dti_pack::TRANSACTION_MAX_NUM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dti_tbu_arb_if.master        bus,
    output logic                 err_len
);

    import dti_pack::*;

    localparam int unsigned PTR_W = (TBU_NUM > 1) ? $clog2(TBU_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_t               state, state_d;
    logic [PTR_W-1:0]         rr_ptr, rr_ptr_d;
    logic [PTR_W-1:0]         gnt_idx, gnt_idx_d;
    logic [PTR_W-1:0]         cand, sel;
    logic                     cand_any;
    logic                     slot_ok, accept, sel_last;
    logic [TBU_NUM-1:0]       s_tready_c;
    logic [CNT_W-1:0]         beat_cnt;

    logic                     m_tvalid_q;
    logic [DATA_WIDTH-1:0]    m_tdata_q;
    logic [KEEP_WIDTH-1:0]    m_tkeep_q;
    logic                     m_tlast_q;
    logic [TBU_NUM_WIDTH-1:0] m_tid_q;
    logic                     err_len_q;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (32'(i) == TBU_NUM - 1) ? '0 : i + 1'b1;
    endfunction

    dti_rr_pick #(
        .TBU_NUM (TBU_NUM),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (bus.s_tvalid),
        .ptr (rr_ptr),
        .idx (cand),
        .any (cand_any)
    );

    // Output register can take a beat when empty or draining this cycle
    assign slot_ok = !m_tvalid_q || bus.m_tready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_d;
            rr_ptr  <= rr_ptr_d;
            gnt_idx <= gnt_idx_d;
        end
    end

    // Grant selection, ready generation and next state
    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        gnt_idx_d  = gnt_idx;
        s_tready_c = '0;
        sel        = cand;
        accept     = 1'b0;
        sel_last   = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                sel = cand;
                if (cand_any) begin
                    s_tready_c[cand] = slot_ok;
                    accept           = slot_ok;
                    sel_last         = bus.s_tlast[cand];
                    if (accept) begin
                        if (sel_last) begin
                            rr_ptr_d = next_idx(cand);
                        end else begin
                            state_d   = ARB_LOCK;
                            gnt_idx_d = cand;
                        end
                    end
                end
            end
            ARB_LOCK: begin
                sel                 = gnt_idx;
                s_tready_c[gnt_idx] = slot_ok;
                accept              = slot_ok && bus.s_tvalid[gnt_idx];
                sel_last            = bus.s_tlast[gnt_idx];
                if (accept && sel_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_idx(gnt_idx);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Upstream output stage: reload on accept, otherwise drain on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
        end else if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= bus.s_tdata[sel];
            m_tkeep_q  <= bus.s_tkeep[sel];
            m_tlast_q  <= sel_last;
            m_tid_q    <= TBU_NUM_WIDTH'(sel);
        end else if (bus.m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    // Message length tracking; err_len is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            err_len_q <= 1'b0;
        end else if (accept) begin
            if (sel_last) begin
                beat_cnt <= '0;
            end else begin
                if (beat_cnt != CNT_W'(MAX_BEATS)) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                    err_len_q <= 1'b1;
                end
            end
        end
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tkeep  = m_tkeep_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tid    = m_tid_q;
    assign err_len      = err_len_q;

endmodule

// File: tb/tb_dti_tbu_arb.sv
// Directed bench for dti_tbu_arb (TBU_NUM=2, 80-bit data, MAX_BEATS=5).
// Inputs change 1 time unit after the rising edge; outputs are checked then
// or on the falling edge, where a recorder also logs every upstream transfer.
module tb_dti_tbu_arb;

    logic clk = 1'b0;
    logic rst_n;
    logic err_len;

    always #5 clk = ~clk;

    dti_tbu_arb_if bus ();

    dti_tbu_arb u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_len (err_len)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hold_seen = 0;

    typedef struct {
        int          cyc;
        logic [5:0]  tid;
        logic [79:0] data;
        logic [9:0]  keep;
        logic        last;
    } beat_t;

    beat_t rec[$];

    logic        prev_hold = 1'b0;
    logic [79:0] prev_data;
    logic [9:0]  prev_keep;
    logic        prev_last;
    logic [5:0]  prev_tid;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer recorder plus stall-stability check on m_*
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_hold) begin
                hold_seen++;
                chk("hold_valid", 128'(bus.m_tvalid), 128'(1'b1));
                chk("hold_data",  128'(bus.m_tdata),  128'(prev_data));
                chk("hold_keep",  128'(bus.m_tkeep),  128'(prev_keep));
                chk("hold_last",  128'(bus.m_tlast),  128'(prev_last));
                chk("hold_tid",   128'(bus.m_tid),    128'(prev_tid));
            end
            if (bus.m_tvalid && bus.m_tready)
                rec.push_back('{cyc, bus.m_tid, bus.m_tdata, bus.m_tkeep, bus.m_tlast});
            prev_hold = bus.m_tvalid && !bus.m_tready;
            prev_data = bus.m_tdata;
            prev_keep = bus.m_tkeep;
            prev_last = bus.m_tlast;
            prev_tid  = bus.m_tid;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rec.delete();
    endtask

    // Hold the current beat on port p until it is accepted (bounded)
    task automatic wait_accept(input int p);
        int   n   = 0;
        logic acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.s_tready[p];
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("accept_p%0d", p), 128'(acc), 128'(1'b1));
    endtask

    task automatic drive_msg(input int p, input int n, input logic [79:0] base);
        for (int k = 0; k < n; k++) begin
            bus.s_tvalid[p] = 1'b1;
            bus.s_tdata[p]  = base + 80'(k);
            bus.s_tkeep[p]  = 10'h3FF ^ 10'(k);
            bus.s_tlast[p]  = (k == n - 1);
            wait_accept(p);
        end
        bus.s_tvalid[p] = 1'b0;
        bus.s_tlast[p]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  exp_tid  [8];
        logic [79:0] exp_data [8];
        logic        exp_last [8];
        logic [15:0] pat;

        // ---- reset state
        do_reset();
        chk("rst_m_tvalid", 128'(bus.m_tvalid), 0);
        chk("rst_m_tlast",  128'(bus.m_tlast),  0);
        chk("rst_m_tdata",  128'(bus.m_tdata),  0);
        chk("rst_m_tkeep",  128'(bus.m_tkeep),  0);
        chk("rst_m_tid",    128'(bus.m_tid),    0);
        chk("rst_err_len",  128'(err_len),      0);
        chk("rst_s_tready", 128'(bus.s_tready), 0);

        // ---- 1: TBU0 3-beat message, one-cycle latency, then rr_ptr=1
        bus.s_tvalid[0] = 1'b1; bus.s_tdata[0] = 80'h100; bus.s_tkeep[0] = 10'h3FF; bus.s_tlast[0] = 1'b0;
        #1;
        chk("t1_rdy0", 128'(bus.s_tready), 128'(2'b01));
        chk("t1_noval", 128'(bus.m_tvalid), 0);
        step();
        chk("t1_b0_valid", 128'(bus.m_tvalid), 1);
        chk("t1_b0_tid",   128'(bus.m_tid),    0);
        chk("t1_b0_data",  128'(bus.m_tdata),  128'(80'h100));
        chk("t1_b0_keep",  128'(bus.m_tkeep),  128'(10'h3FF));
        chk("t1_b0_last",  128'(bus.m_tlast),  0);
        bus.s_tdata[0] = 80'h101; bus.s_tkeep[0] = 10'h0F0;
        step();
        chk("t1_b1_data", 128'(bus.m_tdata), 128'(80'h101));
        chk("t1_b1_keep", 128'(bus.m_tkeep), 128'(10'h0F0));
        bus.s_tdata[0] = 80'h102; bus.s_tlast[0] = 1'b1;
        step();
        chk("t1_b2_data", 128'(bus.m_tdata), 128'(80'h102));
        chk("t1_b2_last", 128'(bus.m_tlast), 1);
        bus.s_tvalid = 2'b11; bus.s_tlast = 2'b11;
        bus.s_tdata[0] = 80'h110; bus.s_tdata[1] = 80'h111;
        #1;
        chk("t1_ptr1_rdy", 128'(bus.s_tready), 128'(2'b10));
        step();
        chk("t1_tid1", 128'(bus.m_tid),   1);
        chk("t1_d1",   128'(bus.m_tdata), 128'(80'h111));
        bus.s_tvalid[1] = 1'b0;
        #1;
        chk("t1_ptr0_rdy", 128'(bus.s_tready), 128'(2'b01));
        step();
        chk("t1_tid0", 128'(bus.m_tid),   0);
        chk("t1_d0",   128'(bus.m_tdata), 128'(80'h110));
        bus.s_tvalid = '0; bus.s_tlast = '0;
        step();
        chk("t1_drained", 128'(bus.m_tvalid), 0);

        // ---- 2: both TBUs continuously valid, 2-beat messages
        do_reset();
        fork
            begin
                drive_msg(0, 2, 80'h200);
                drive_msg(0, 2, 80'h210);
            end
            begin
                drive_msg(1, 2, 80'h300);
                drive_msg(1, 2, 80'h310);
            end
        join
        step(); step();
        exp_tid  = '{0, 0, 1, 1, 0, 0, 1, 1};
        exp_data = '{80'h200, 80'h201, 80'h300, 80'h301, 80'h210, 80'h211, 80'h310, 80'h311};
        exp_last = '{0, 1, 0, 1, 0, 1, 0, 1};
        chk("t2_count", 128'(rec.size()), 8);
        for (int i = 0; i < 8 && i < rec.size(); i++) begin
            chk($sformatf("t2_tid%0d", i),  128'(rec[i].tid),  128'(exp_tid[i]));
            chk($sformatf("t2_data%0d", i), 128'(rec[i].data), 128'(exp_data[i]));
            chk($sformatf("t2_last%0d", i), 128'(rec[i].last), 128'(exp_last[i]));
            chk($sformatf("t2_nobubble%0d", i), 128'(rec[i].cyc - rec[0].cyc), 128'(i));
        end

        // ---- 3: TBU1 waits while TBU0 4-beat message is locked
        do_reset();
        bus.s_tvalid[0] = 1'b1; bus.s_tdata[0] = 80'h400; bus.s_tlast[0] = 1'b0;
        step();
        bus.s_tdata[0] = 80'h401;
        bus.s_tvalid[1] = 1'b1; bus.s_tdata[1] = 80'h500; bus.s_tlast[1] = 1'b1;
        #1;
        chk("t3_rdy_b1", 128'(bus.s_tready), 128'(2'b01));
        step();
        bus.s_tdata[0] = 80'h402;
        #1;
        chk("t3_rdy_b2", 128'(bus.s_tready), 128'(2'b01));
        step();
        bus.s_tdata[0] = 80'h403; bus.s_tlast[0] = 1'b1;
        #1;
        chk("t3_rdy_b3", 128'(bus.s_tready), 128'(2'b01));
        step();
        bus.s_tvalid[0] = 1'b0; bus.s_tlast[0] = 1'b0;
        #1;
        chk("t3_rdy_tbu1", 128'(bus.s_tready), 128'(2'b10));
        chk("t3_last_tid",  128'(bus.m_tid),   0);
        chk("t3_last_data", 128'(bus.m_tdata), 128'(80'h403));
        chk("t3_last_last", 128'(bus.m_tlast), 1);
        step();
        chk("t3_tbu1_tid",  128'(bus.m_tid),   1);
        chk("t3_tbu1_data", 128'(bus.m_tdata), 128'(80'h500));
        bus.s_tvalid[1] = 1'b0; bus.s_tlast[1] = 1'b0;
        step();
        chk("t3_drained", 128'(bus.m_tvalid), 0);

        // ---- 4: upstream ready toggling during a 5-beat message
        do_reset();
        hold_seen = 0;
        pat = 16'b1010_0110_0101_1001;
        fork
            drive_msg(0, 5, 80'h600);
            begin
                for (int i = 0; i < 40; i++) begin
                    bus.m_tready = pat[i % 16];
                    step();
                end
                bus.m_tready = 1'b1;
            end
        join
        step(); step();
        chk("t4_count", 128'(rec.size()), 5);
        for (int i = 0; i < 5 && i < rec.size(); i++) begin
            chk($sformatf("t4_data%0d", i), 128'(rec[i].data), 128'(80'h600 + 80'(i)));
            chk($sformatf("t4_keep%0d", i), 128'(rec[i].keep), 128'(10'h3FF ^ 10'(i)));
            chk($sformatf("t4_last%0d", i), 128'(rec[i].last), 128'(i == 4));
        end
        chk("t4_hold_seen", 128'(hold_seen > 0), 1);
        chk("t4_no_err", 128'(err_len), 0);

        // ---- 5: 6-beat message trips err_len after the 5th beat
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.s_tvalid[0] = 1'b1;
            bus.s_tdata[0]  = 80'h700 + 80'(k);
            bus.s_tkeep[0]  = 10'h3FF;
            bus.s_tlast[0]  = (k == 5);
            #1;
            chk($sformatf("t5_rdy%0d", k), 128'(bus.s_tready[0]), 1);
            step();
            chk($sformatf("t5_data%0d", k), 128'(bus.m_tdata), 128'(80'h700 + 80'(k)));
            chk($sformatf("t5_err%0d", k),  128'(err_len),     128'(k >= 4));
        end
        bus.s_tvalid[0] = 1'b0; bus.s_tlast[0] = 1'b0;
        step();
        chk("t5_err_sticky", 128'(err_len),      1);
        chk("t5_drained",    128'(bus.m_tvalid), 0);

        // ---- 6: reset mid-message restores TBU0 priority and clears err_len
        bus.s_tvalid[1] = 1'b1; bus.s_tdata[1] = 80'h800; bus.s_tlast[1] = 1'b0;
        #1;
        chk("t6_rdy_tbu1", 128'(bus.s_tready), 128'(2'b10));
        step();
        chk("t6_valid_pre", 128'(bus.m_tvalid), 1);
        chk("t6_tid_pre",   128'(bus.m_tid),    1);
        rst_n = 1'b0;
        bus.s_tvalid = '0;
        #1;
        chk("t6_rst_valid", 128'(bus.m_tvalid), 0);
        chk("t6_rst_err",   128'(err_len),      0);
        chk("t6_rst_data",  128'(bus.m_tdata),  0);
        step(); step();
        rst_n = 1'b1;
        bus.s_tvalid = 2'b11; bus.s_tlast = 2'b11;
        bus.s_tdata[0] = 80'h900; bus.s_tdata[1] = 80'h901;
        #1;
        chk("t6_prio_rdy", 128'(bus.s_tready), 128'(2'b01));
        step();
        chk("t6_prio_tid",  128'(bus.m_tid),   0);
        chk("t6_prio_data", 128'(bus.m_tdata), 128'(80'h900));
        bus.s_tvalid = '0; bus.s_tlast = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dti_tbu_arb.md
# dti_tbu_arb

Packet-level round-robin arbiter that shares the single upstream DTI AXI-Stream link toward the TCU between `TBU_NUM` TBU-side AXI-Stream masters. A grant is held from the first beat of a message until its `tlast` beat, so messages are never interleaved. Each forwarded beat carries the source TBU index on `m_tid`. The block sits between the per-TBU DTI ports and the NoC upstream link, has one output register stage, and flags over-length messages.

## Interface
- `TBU_NUM`, default 2, number of requesting TBU ports (≥2).
- `TBU_NUM_WIDTH`, default 6, width of `m_tid`.
- `DATA_WIDTH`, default `AXIS_DATA_WIDTH` (80), tdata width.
- `KEEP_WIDTH`, default `DATA_WIDTH/8` (10), tkeep width.
- `MAX_BEATS`, default `TRANSACTION_MAX_NUM` (5), maximum legal beats per message.
- `clk`, in, 1, single clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `s_tvalid`, in, `TBU_NUM`, per-TBU valid.
- `s_tready`, out, `TBU_NUM`, per-TBU ready.
- `s_tdata`, in, `TBU_NUM`×`DATA_WIDTH`, per-TBU data.
- `s_tkeep`, in, `TBU_NUM`×`KEEP_WIDTH`, per-TBU byte enables.
- `s_tlast`, in, `TBU_NUM`, per-TBU end of message.
- `m_tvalid`, out, 1, upstream valid (registered).
- `m_tready`, in, 1, upstream ready.
- `m_tdata`, out, `DATA_WIDTH`, upstream data (registered).
- `m_tkeep`, out, `KEEP_WIDTH`, upstream byte enables (registered).
- `m_tlast`, out, 1, upstream end of message (registered).
- `m_tid`, out, `TBU_NUM_WIDTH`, source TBU index, zero-extended (registered).
- `err_len`, out, 1, sticky over-length message flag.

## Operation
- FSM states:
  - IDLE: no message in progress.
  - LOCK: grant held on `gnt_idx`.
- Slot available: `slot_ok = !m_tvalid || m_tready`.
- IDLE:
  - Candidate = first index with `s_tvalid` set, searching `rr_ptr`, `rr_ptr+1`, … mod `TBU_NUM`.
  - `s_tready[cand] = slot_ok`. All other `s_tready` bits are 0.
  - On accept with `tlast=0`: go to LOCK and latch `gnt_idx = cand`.
  - On accept with `tlast=1`: stay in IDLE and set `rr_ptr = cand+1 mod TBU_NUM`.
- LOCK:
  - `s_tready[gnt_idx] = slot_ok`. All other `s_tready` bits are 0.
  - Valid inputs on other ports are ignored and must hold per AXI-S rules.
  - On accepting the `tlast` beat: go to IDLE and set `rr_ptr = gnt_idx+1 mod TBU_NUM`.
- Accepted beat:
  - Loads the output register with `tdata`, `tkeep`, `tlast`, and the index.
  - Sets `m_tvalid`.
- `m_tvalid` clears when `m_tready=1` and no new beat is accepted in the same cycle.
- Beat counter `beat_cnt`:
  - Increments on each accepted beat and resets to 0 on an accepted `tlast` beat.
  - Saturates at `MAX_BEATS`.
  - An accepted beat with `beat_cnt == MAX_BEATS-1` and `tlast=0` sets `err_len`.
  - `err_len` is cleared only by reset.
  - Traffic is not altered; the grant stays locked until `tlast`.
- Reset values:
  - State IDLE; `rr_ptr`, `gnt_idx`, `beat_cnt` = 0.
  - `m_tvalid`, `m_tlast`, `err_len` = 0.
  - `m_tdata`, `m_tkeep`, `m_tid` = 0.
- Reset asserted mid-message: the message is dropped and the block returns to reset values immediately. Senders must restart.

## Timing
- Latency: input accept in cycle N gives `m_tvalid` in cycle N+1.
- Full throughput: one beat per cycle while `m_tready=1`.
- `s_tready` is combinational from state, `s_tvalid`, `m_tvalid` and `m_tready`. There is no combinational path from `s_tdata` to any output.
- Arbitration is decided in the same cycle a first beat is presented. No idle bubble between back-to-back messages, from the same or different TBUs.
- `m_tready` low holds all `m_*` stable and deasserts all `s_tready`.
- Simultaneous `m_tready` drain and new accept in one cycle: the register reloads and `m_tvalid` stays 1.

## Structure
- Add to `dti_pack`:
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_LOCK} arb_state_t`.
  - `MAX_BEATS` is sourced from `TRANSACTION_MAX_NUM`.
  - Width constants are taken from the existing `AXIS_*` and `TBU_NUM*` constants.
- One natural sub-module, `dti_rr_pick`: combinational round-robin first-one search, taking `req[TBU_NUM]` and `ptr` and producing `idx` and `any`.

## Test plan
- TBU0 sends a 3-beat message with `m_tready=1`: `m_tid`=0, 3 consecutive beats, output starting 1 cycle after the first accept, `tlast` on beat 3, `rr_ptr`=1.
- Both TBUs continuously valid with 2-beat messages from reset: output order TBU0, TBU1, TBU0, TBU1, with no interleaving and no bubbles.
- TBU1 asserts valid mid-way through a TBU0 4-beat message: `s_tready[1]`=0 until the TBU0 `tlast` is accepted, then TBU1 is granted the next cycle.
- `m_tready` toggled 1/0 randomly during a 5-beat message: data intact and in order, `m_*` stable while `m_tready`=0.
- TBU0 sends 6 beats with `tlast` on beat 6: `err_len` rises in the cycle after beat 5 is accepted, all 6 beats are forwarded, and `err_len` stays 1.
- `rst_n` pulled low mid-message: `m_tvalid`=0 and `err_len`=0 during reset; after release TBU0 has first priority again.
